// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus drain controller in front of a uart transmitter.
// Producers push bytes at core rate. The block hands them to the uart one at a time
// and paces itself on tx_busy, so producers never need to watch the uart.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   wr_data, wr_en     enqueue a byte
//   flush              synchronous clear of the stored bytes; a byte already handed
//                      to the uart still completes
//   full, empty, count FIFO occupancy
//   overflow           1-cycle pulse: a write was dropped because the FIFO was full
//   tx_err             1-cycle pulse: tx_busy never rose after a tx_send
//   tx_data, tx_send   registered byte and 1-cycle send strobe to the uart
//   tx_busy            uart transmitter busy
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_err,
  output logic [7:0]            tx_data,
  output logic                  tx_send,
  input  logic                  tx_busy
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int WW    = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_send_q, tx_send_d;
  logic                  overflow_q, overflow_d;
  logic                  tx_err_q, tx_err_d;
  logic [7:0]            mem_q [DEPTH];

  logic pop, wr_acc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // The only pop is the IDLE -> WAIT_BUSY launch; a pop frees a slot on the same
  // edge, so a write into a full FIFO is still accepted then.
  assign pop    = (state_q == IDLE) && !empty && !flush;
  assign wr_acc = wr_en && !flush && (!full || pop);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wait_d     = wait_q;
    tx_data_d  = tx_data_q;
    tx_send_d  = 1'b0;
    tx_err_d   = 1'b0;
    overflow_d = wr_en && full && !pop && !flush;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_acc, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          tx_send_d = 1'b1;
          wait_d    = '0;
          state_d   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (wait_q == WW'(BUSY_WAIT - 1)) begin
          // uart never acknowledged; give up on this byte rather than stall
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      tx_data_q  <= '0;
      tx_send_q  <= 1'b0;
      overflow_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      tx_data_q  <= tx_data_d;
      tx_send_q  <= tx_send_d;
      overflow_q <= overflow_d;
      tx_err_q   <= tx_err_d;
    end
  end

  // Storage carries no reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_err   = tx_err_q;
  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: table-driven fill/overflow phase plus hand-written
// sequences for latency, full+pop, lost send, flush and mid-operation reset.
module tb_uart_tx_fifo;

  localparam int BUSY_LEN = 5;
  localparam logic [1:0] M_AUTO = 2'd0, M_HIGH = 2'd1, M_LOW = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_en, flush;
  logic       full, empty, overflow, tx_err, tx_send;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_busy;

  logic [1:0] busy_mode;
  logic       auto_busy;
  int         busy_cnt;
  logic [7:0] sent[$];
  logic       prev_send;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(4), .BUSY_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .tx_err(tx_err),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy)
  );

  assign tx_busy = (busy_mode == M_AUTO) ? auto_busy : (busy_mode == M_HIGH);

  // uart stand-in: busy rises the cycle after it sees tx_send, stays up BUSY_LEN cycles
  initial begin
    auto_busy = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(posedge clk); #2;
      if (busy_cnt > 0) begin auto_busy = 1'b1; busy_cnt--; end
      else auto_busy = 1'b0;
      if (busy_mode == M_AUTO && tx_send) busy_cnt = BUSY_LEN;
    end
  end

  // Log every send; check pulse width and that no send overlaps uart busy
  initial begin
    prev_send = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_send) begin
        sent.push_back(tx_data);
        checks++;
        if (prev_send) begin
          failures++;
          $display("FAIL send_width tx_send high on consecutive cycles");
        end
        if (busy_mode == M_AUTO) begin
          checks++;
          if (tx_busy) begin
            failures++;
            $display("FAIL send_while_busy tx_send=1 with tx_busy=1");
          end
        end
      end
      prev_send = tx_send;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_sent(input int n, input int bound);
    int c = 0;
    while (sent.size() < n && c < bound) begin @(posedge clk); c++; end
    #1;
    chk("wait_sent", sent.size() >= n, 1);
  endtask

  task automatic chk_sent(input string nm, input int idx, input logic [7:0] exp);
    logic [7:0] b;
    b = (idx < sent.size()) ? sent[idx] : 8'hxx;
    chk(nm, b, exp);
  endtask

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // fill table: 17 writes into a stalled FIFO, then one idle cycle
    for (int k = 0; k < 17; k++)
      tbl[k] = '{1'b1, 8'(k), (k >= 15) ? 5'd16 : 5'(k + 1), (k >= 15), 1'b0, (k == 16)};
    tbl[17] = '{1'b0, 8'hEE, 5'd16, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; busy_mode = M_LOW;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_send", tx_send, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", tx_err, 0);
    rst_n = 1'b1;
    repeat (10) step();
    chk("rst_no_send", sent.size(), 0);

    // ---- basic drain with first-write latency
    busy_mode = M_AUTO;
    wr_en = 1'b1; wr_data = 8'h55; step();
    chk("lat_n_send", tx_send, 0);
    chk("lat_n_count", count, 1);
    wr_data = 8'hA3; step();
    chk("lat_n1_send", tx_send, 1);
    chk("lat_n1_data", tx_data, 8'h55);
    wr_data = 8'h0F; step();
    wr_en = 1'b0;
    wait_sent(3, 400);
    repeat (40) step();
    chk("drain_n", sent.size(), 3);
    chk_sent("drain_0", 0, 8'h55);
    chk_sent("drain_1", 1, 8'hA3);
    chk_sent("drain_2", 2, 8'h0F);
    chk("drain_empty", empty, 1);

    // ---- overflow: park FSM in WAIT_DONE with busy held high
    busy_mode = M_HIGH;
    wr_en = 1'b1; wr_data = 8'hAA; step();
    wr_en = 1'b0;
    repeat (4) step();
    chk("prime_count", count, 0);
    sent.delete();
    for (int i = 0; i < 18; i++) begin
      wr_en = tbl[i].wr_en; wr_data = tbl[i].wr_data;
      step();
      chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_count);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].exp_full);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].exp_empty);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].exp_ovf);
      chk($sformatf("tbl%0d_send", i), tx_send, 0);
    end
    wr_en = 1'b0;

    // ---- full + pop: write on the launch edge
    busy_mode = M_LOW;
    step();                              // WAIT_DONE -> IDLE
    chk("fp_pre_count", count, 16);
    chk("fp_pre_send", tx_send, 0);
    wr_en = 1'b1; wr_data = 8'h77; step(); // pop + write
    wr_en = 1'b0;
    busy_mode = M_AUTO;
    chk("fp_count", count, 16);
    chk("fp_full", full, 1);
    chk("fp_ovf", overflow, 0);
    chk("fp_send", tx_send, 1);
    chk("fp_data", tx_data, 8'h00);
    wait_sent(17, 2000);
    repeat (40) step();
    chk("fp_n", sent.size(), 17);
    for (int i = 0; i < 16; i++) chk_sent($sformatf("fp_byte%0d", i), i, 8'(i));
    chk_sent("fp_last", 16, 8'h77);
    chk("fp_empty", empty, 1);

    // ---- lost send: tx_busy stuck low
    busy_mode = M_LOW;
    sent.delete();
    wr_en = 1'b1; wr_data = 8'h3C; step();
    wr_data = 8'h5A; step();
    wr_en = 1'b0;
    chk("lost_send", tx_send, 1);
    chk("lost_data", tx_data, 8'h3C);
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("lost_err_c%0d", c), tx_err, (c == 4));
    end
    chk("lost_next_send", tx_send, 1);
    chk("lost_next_data", tx_data, 8'h5A);
    repeat (10) step();
    chk("lost_n", sent.size(), 2);

    // ---- flush during WAIT_DONE with 5 queued
    busy_mode = M_HIGH;
    sent.delete();
    wr_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin wr_data = 8'(i * 8'h11); step(); end
    wr_en = 1'b0;
    chk("fl_pre_count", count, 5);
    flush = 1'b1; step();
    flush = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    busy_mode = M_LOW;
    repeat (12) step();
    chk("fl_n", sent.size(), 1);
    chk_sent("fl_inflight", 0, 8'h11);

    // ---- reset during WAIT_DONE
    busy_mode = M_HIGH;
    wr_en = 1'b1; wr_data = 8'h99; step();
    wr_data = 8'h88; step();
    wr_en = 1'b0;
    repeat (2) step();
    chk("mr_pre_data", tx_data, 8'h99);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_send", tx_send, 0);
    chk("mr_data", tx_data, 8'h00);
    chk("mr_count", count, 0);
    chk("mr_empty", empty, 1);
    chk("mr_full", full, 0);
    chk("mr_ovf", overflow, 0);
    chk("mr_err", tx_err, 0);
    step();
    rst_n = 1'b1;
    busy_mode = M_LOW;
    sent.delete();
    repeat (10) step();
    chk("mr_no_send", sent.size(), 0);
    wr_en = 1'b1; wr_data = 8'hC5; step();
    wr_en = 1'b0;
    wait_sent(1, 50);
    chk_sent("mr_after", 0, 8'hC5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
